// File: rtl/riscv_pkg.sv
// Shared writeback types: register address width, data width and the
// {rd, data} entry carried through the long-latency result FIFO.
package riscv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ENTRY_W    = REG_ADDR_W + XLEN;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for long-latency writeback entries. Head is read
// combinationally from storage; there is no input-to-output bypass.
module wb_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ENTRY_W-1:0]       din,
  output logic [ENTRY_W-1:0]       dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/wb_arbiter.sv
// Merges single-cycle ALU results and buffered long-latency results into one
// registered register-file write per cycle, with a starvation-driven ALU stall.
module wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int XLEN         = riscv_pkg::XLEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  input  logic [4:0]             alu_rd,
  input  logic [XLEN-1:0]        alu_data,
  input  logic                   lsu_valid,
  output logic                   lsu_ready,
  input  logic [4:0]             lsu_rd,
  input  logic [XLEN-1:0]        lsu_data,
  output logic                   alu_stall,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   reg_write,
  output logic [4:0]             write_reg,
  output logic [XLEN-1:0]        write_data
);
  import riscv_pkg::*;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  wb_entry_t     push_entry;
  wb_entry_t     head_entry;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          alu_write;
  logic          alu_win;
  logic [SW-1:0] starve_cnt;
  logic [SW-1:0] starve_next;

  // Handshake: a long-latency result transfers on any cycle with
  // lsu_valid && lsu_ready; lsu_ready depends only on registered occupancy.
  assign lsu_ready  = !fifo_full;
  assign push       = lsu_valid && lsu_ready && (lsu_rd != '0);
  assign alu_write  = alu_valid && (alu_rd != '0);
  assign alu_win    = alu_write && !alu_stall;
  assign pop        = !alu_win && !fifo_empty;
  assign push_entry = '{rd: lsu_rd, data: lsu_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Counts ALU wins over a waiting head; any pop or an empty FIFO resets it.
  always_comb begin
    starve_next = starve_cnt;
    if (pop || fifo_empty) starve_next = '0;
    else if (alu_win && (starve_cnt != STARVE_MAX)) starve_next = starve_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      starve_cnt <= '0;
      alu_stall  <= 1'b0;
    end else begin
      starve_cnt <= starve_next;
      alu_stall  <= (starve_next == STARVE_MAX);
      reg_write  <= alu_win || pop;
      if (alu_win) begin
        write_reg  <= alu_rd;
        write_data <= alu_data;
      end else if (pop) begin
        write_reg  <= head_entry.rd;
        write_data <= head_entry.data;
      end
    end
  end

  a_no_alu_during_stall: assert property (@(posedge clk) disable iff (rst) !(alu_valid && alu_stall));
  a_no_x0_write: assert property (@(posedge clk) disable iff (rst) reg_write |-> (write_reg != '0));
endmodule
